ccc_lock_reset_seq: RTL and testbench
=====================================

Name: ccc_lock_reset_seq

Overview:
Parametrised PLL power-up, lock-qualification and reset-release sequencer for fabric clock domains driven by a CCC/PLL.
- Drives the PLL's active-low powerdown.
- Synchronises and qualifies the PLL lock signal, then releases NUM_OUT fabric resets in a staggered order.
- On loss of lock, re-asserts all resets and power-cycles the PLL, with bounded retry and a sticky fault.
- Sits beside each CCC instance and runs on the free-running reference clock.

Parameters:
NUM_OUT, 3, number of staggered fabric reset outputs (1..8)
PD_CYCLES, 16, cycles PLL_POWERDOWN_N_0 is held low per power cycle (>=2)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before a retry is counted
LOCK_STABLE_CYCLES, 256, consecutive synchronised-lock-high cycles required before release
STAGGER, 8, cycles between successive reset-bit releases (>=1)
RETRY_LIMIT, 3, failed attempts tolerated before FAULT (>=1)

Ports:
REF_CLK_0  in  1  free-running reference clock; all logic on rising edge
RST_0  in  1  synchronous, active-high reset
PLL_ENABLE_0  in  1  1 = run sequence; 0 = hold PLL powered down
PLL_LOCK_0  in  1  raw PLL lock, asynchronous to REF_CLK_0
PLL_POWERDOWN_N_0  out  1  to PLL POWERDOWN_N; 0 = powered down
FABRIC_RESET_N  out  NUM_OUT  active-low domain resets; bit 0 is released first
READY  out  1  all resets released, lock holding
FAULT  out  1  sticky; retries exhausted
RETRY_CNT  out  $clog2(RETRY_LIMIT+1)  failed attempts since reset or last RUN entry

Behaviour:
- Reset (RST_0=1 at an edge) forces:
  - PLL_POWERDOWN_N_0=0, FABRIC_RESET_N=all 0, READY=0, FAULT=0, RETRY_CNT=0
  - state=PWRDN, counters cleared, lock sync flops cleared
- Reset applies at any point mid-sequence, including in FAULT.
- Lock synchroniser: 2-flop; lock_s lags PLL_LOCK_0 by 2 cycles. Only lock_s is used below.
- PWRDN:
  - PLL_POWERDOWN_N_0=0 and all resets asserted.
  - Counts PD_CYCLES cycles while PLL_ENABLE_0=1; PLL_ENABLE_0=0 holds the count at 0.
  - At count completion goes to WAIT_LOCK; PLL_POWERDOWN_N_0=1 from the next cycle.
  - After reset, PLL_POWERDOWN_N_0 is therefore low for exactly PD_CYCLES cycles when PLL_ENABLE_0=1.
- WAIT_LOCK:
  - lock_s=1 -> STABLE, stable counter=1.
  - LOCK_TIMEOUT cycles elapse -> attempt failed (see fail rule).
- STABLE:
  - lock_s=0 -> WAIT_LOCK; timeout counter restarts; no retry is counted.
  - Counter reaches LOCK_STABLE_CYCLES -> RELEASE; FABRIC_RESET_N[0]=1 in the first RELEASE cycle.
- RELEASE:
  - Bit k goes high k*STAGGER cycles after bit 0.
  - Once a bit is released it stays high until a fail or reset.
  - One cycle after bit NUM_OUT-1 is released -> RUN; READY=1 and RETRY_CNT cleared to 0.
- RUN: holds until lock_s=0 (fail).
- Fail rule:
  - Applies on lock_s=0 in RELEASE or RUN, and on timeout in WAIT_LOCK.
  - Next cycle: all FABRIC_RESET_N=0, READY=0, PLL_POWERDOWN_N_0=0.
  - If RETRY_CNT+1 < RETRY_LIMIT: RETRY_CNT increments, state -> PWRDN.
  - Otherwise: RETRY_CNT saturates at RETRY_LIMIT, FAULT=1, state -> FAULT.
- FAULT: PLL held powered down, resets asserted; exit only via RST_0.
- PLL_ENABLE_0=0 in any non-FAULT state -> PWRDN next cycle with all resets asserted. RETRY_CNT is unchanged.
- Simultaneous events:
  - RST_0 dominates everything.
  - PLL_ENABLE_0=0 dominates lock loss: no retry is counted.
  - Lock loss on the same cycle as STABLE completion: treated as lock loss, returns to WAIT_LOCK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
LOCK_LOSS_COUNTER_EN
- Defined: adds output LOCK_LOSS_CNT[15:0].
  - Increments once per RUN->fail transition.
  - Saturates at 16'hFFFF; cleared only by RST_0, not by RUN entry.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
Parameters for all cases: NUM_OUT=3, PD_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE_CYCLES=16, STAGGER=8, RETRY_LIMIT=2.
1. Clean start: release RST_0 with PLL_ENABLE_0=1, raise PLL_LOCK_0 10 cycles after POWERDOWN_N rises -> POWERDOWN_N low exactly 4 cycles; reset bits rise at offsets 0/8/16 after 2+16 qualified cycles; READY 1 cycle after bit 2.
2. Lock glitch during STABLE: drop PLL_LOCK_0 for 1 cycle at stable count 10 -> no release, RETRY_CNT stays 0, qualification restarts, full 16-cycle count required.
3. Lock loss in RUN: drop lock -> next-cycle-after-sync FABRIC_RESET_N=3'b000, READY=0, POWERDOWN_N=0 for 4 cycles, RETRY_CNT=1; relock -> RUN with RETRY_CNT=0 (and LOCK_LOSS_CNT=1 when LOCK_LOSS_COUNTER_EN is defined).
4. Lock never asserts -> timeout after 64 cycles, RETRY_CNT=1, second timeout -> FAULT=1, RETRY_CNT=2; PLL held down until RST_0 clears everything.
5. PLL_ENABLE_0 deasserted mid-RELEASE (after bit 1) -> all bits 0 next cycle, RETRY_CNT unchanged; re-enable -> full sequence repeats.
6. RST_0 pulsed for 1 cycle in RUN -> all outputs return to reset values on that edge; sequence restarts from PWRDN.

Source files
------------

// File: rtl/ccc_lock_reset_seq.sv
// ccc_lock_reset_seq: PLL power-up, lock qualification and staggered fabric
// reset release for one CCC/PLL instance, clocked by the free-running
// reference clock.
// Optional feature macro: LOCK_LOSS_COUNTER_EN adds LOCK_LOSS_CNT[15:0],
// a saturating count of lock losses seen while in RUN.
module ccc_lock_reset_seq #(
  parameter int NUM_OUT            = 3,
  parameter int PD_CYCLES          = 16,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGGER            = 8,
  parameter int RETRY_LIMIT        = 3
) (
  input  logic                               REF_CLK_0,
  input  logic                               RST_0,
  input  logic                               PLL_ENABLE_0,
  input  logic                               PLL_LOCK_0,
  output logic                               PLL_POWERDOWN_N_0,
  output logic [NUM_OUT-1:0]                 FABRIC_RESET_N,
  output logic                               READY,
  output logic                               FAULT,
  output logic [$clog2(RETRY_LIMIT+1)-1:0]   RETRY_CNT
`ifdef LOCK_LOSS_COUNTER_EN
  ,
  output logic [15:0]                        LOCK_LOSS_CNT
`endif
);

  // Release of the last reset bit happens this many cycles after bit 0.
  localparam int REL_LAST = (NUM_OUT - 1) * STAGGER;
  // One shared phase counter, wide enough for the longest phase.
  localparam int M1   = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
  localparam int M2   = (M1 > LOCK_STABLE_CYCLES) ? M1 : LOCK_STABLE_CYCLES;
  localparam int CMAX = (M2 > REL_LAST) ? M2 : REL_LAST;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [2:0] {
    S_PWRDN,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 lock_meta_q, lock_s_q;
  logic                 pd_n_q, pd_n_d;
  logic [NUM_OUT-1:0]   rst_n_q, rst_n_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 fail;
  logic                 go_pwrdn;

  // Lock synchroniser, state register and registered outputs.
  always_ff @(posedge REF_CLK_0) begin
    if (RST_0) begin
      state_q     <= S_PWRDN;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pd_n_q      <= 1'b0;
      rst_n_q     <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= PLL_LOCK_0;
      lock_s_q    <= lock_meta_q;
      pd_n_q      <= pd_n_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
    end
  end

  // Next-state, phase counter and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_n_d  = rst_n_q;
    ready_d  = ready_q;
    fault_d  = fault_q;
    retry_d  = retry_q;
    fail     = 1'b0;
    go_pwrdn = 1'b0;

    unique case (state_q)
      S_PWRDN: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        if (!PLL_ENABLE_0) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(PD_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_LOCK: begin
        if (!PLL_ENABLE_0) begin
          go_pwrdn = 1'b1;
        end else if (lock_s_q) begin
          // The sampling cycle itself is the first qualified cycle.
          if (LOCK_STABLE_CYCLES <= 1) begin
            state_d    = S_RELEASE;
            cnt_d      = '0;
            rst_n_d    = '0;
            rst_n_d[0] = 1'b1;
          end else begin
            state_d = S_STABLE;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STABLE: begin
        if (!PLL_ENABLE_0) begin
          go_pwrdn = 1'b1;
        end else if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d    = S_RELEASE;
          cnt_d      = '0;
          rst_n_d    = '0;
          rst_n_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RELEASE: begin
        if (!PLL_ENABLE_0) begin
          go_pwrdn = 1'b1;
        end else if (!lock_s_q) begin
          fail = 1'b1;
        end else if (cnt_q == CW'(REL_LAST)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          for (int unsigned k = 0; k < NUM_OUT; k++) begin
            rst_n_d[k] = (32'(cnt_d) >= k * 32'(STAGGER));
          end
        end
      end

      S_RUN: begin
        if (!PLL_ENABLE_0) begin
          go_pwrdn = 1'b1;
        end else if (!lock_s_q) begin
          fail = 1'b1;
        end
      end

      S_FAULT: begin
        rst_n_d = '0;
        ready_d = 1'b0;
      end

      default: begin
        state_d = S_PWRDN;
        cnt_d   = '0;
      end
    endcase

    if (go_pwrdn) begin
      state_d = S_PWRDN;
      cnt_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end

    if (fail) begin
      cnt_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      if (32'(retry_q) + 32'd1 < 32'(RETRY_LIMIT)) begin
        retry_d = retry_q + RW'(1);
        state_d = S_PWRDN;
      end else begin
        retry_d = RW'(RETRY_LIMIT);
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    end

    pd_n_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) ||
             (state_d == S_RELEASE)   || (state_d == S_RUN);
  end

  assign PLL_POWERDOWN_N_0 = pd_n_q;
  assign FABRIC_RESET_N    = rst_n_q;
  assign READY             = ready_q;
  assign FAULT             = fault_q;
  assign RETRY_CNT         = retry_q;

`ifdef LOCK_LOSS_COUNTER_EN
  logic [15:0] llc_q;

  // Saturating count of lock losses taken from RUN; only RST_0 clears it.
  always_ff @(posedge REF_CLK_0) begin
    if (RST_0) begin
      llc_q <= '0;
    end else if ((state_q == S_RUN) && PLL_ENABLE_0 && !lock_s_q &&
                 (llc_q != '1)) begin
      llc_q <= llc_q + 16'd1;
    end
  end

  assign LOCK_LOSS_CNT = llc_q;
`else
  // Without the counter, a lock loss in RUN only feeds the retry logic.
`endif

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: directed scenarios plus randomized
// enable/lock/reset traffic, every cycle checked against a phase/elapsed-time
// reference model of the sequencer.
module tb_ccc_lock_reset_seq;

  localparam int NO  = 3;
  localparam int PD  = 4;
  localparam int TO  = 64;
  localparam int LSC = 16;
  localparam int ST  = 8;
  localparam int RL  = 2;
  localparam int RW  = $clog2(RL + 1);

  localparam int PH_DOWN = 0, PH_WAIT = 1, PH_QUAL = 2, PH_REL = 3,
                 PH_RUN = 4, PH_FAULT = 5;

  logic          clk = 1'b0;
  logic          rst, en, lock;
  logic          pd_n, ready, fault;
  logic [NO-1:0] rst_n;
  logic [RW-1:0] retry;
`ifdef LOCK_LOSS_COUNTER_EN
  logic [15:0]   llc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: phase, cycles elapsed in it, lock history.
  int          m_phase;
  int unsigned m_t, m_retry, m_llc;
  bit          m_fault;
  bit          h1, h2;

  always #5 clk = ~clk;

  ccc_lock_reset_seq #(
    .NUM_OUT(NO), .PD_CYCLES(PD), .LOCK_TIMEOUT(TO),
    .LOCK_STABLE_CYCLES(LSC), .STAGGER(ST), .RETRY_LIMIT(RL)
  ) dut (
    .REF_CLK_0(clk),
    .RST_0(rst),
    .PLL_ENABLE_0(en),
    .PLL_LOCK_0(lock),
    .PLL_POWERDOWN_N_0(pd_n),
    .FABRIC_RESET_N(rst_n),
    .READY(ready),
    .FAULT(fault),
    .RETRY_CNT(retry)
`ifdef LOCK_LOSS_COUNTER_EN
    ,
    .LOCK_LOSS_CNT(llc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_fail();
    m_t = 0;
    if (m_retry + 1 < RL) begin
      m_retry++;
      m_phase = PH_DOWN;
    end else begin
      m_retry = RL;
      m_fault = 1'b1;
      m_phase = PH_FAULT;
    end
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit l);
    bit ls;
    ls = h2;           // lock as seen two edges late
    h2 = h1;
    h1 = l;
    if (r) begin
      h1 = 0; h2 = 0;
      m_phase = PH_DOWN; m_t = 0; m_retry = 0; m_fault = 0; m_llc = 0;
    end else if (m_phase == PH_FAULT) begin
      // only reset leaves FAULT
    end else if (!e) begin
      m_phase = PH_DOWN; m_t = 0;
    end else begin
      case (m_phase)
        PH_DOWN: begin
          m_t++;
          if (m_t == PD) begin m_phase = PH_WAIT; m_t = 0; end
        end
        PH_WAIT: begin
          if (ls) begin m_phase = PH_QUAL; m_t = 1; end
          else begin
            m_t++;
            if (m_t == TO) model_fail();
          end
        end
        PH_QUAL: begin
          if (!ls) begin m_phase = PH_WAIT; m_t = 0; end
          else begin
            m_t++;
            if (m_t == LSC) begin m_phase = PH_REL; m_t = 0; end
          end
        end
        PH_REL: begin
          if (!ls) model_fail();
          else if (m_t == (NO - 1) * ST) begin m_phase = PH_RUN; m_retry = 0; end
          else m_t++;
        end
        PH_RUN: begin
          if (!ls) begin
            if (m_llc < 16'hFFFF) m_llc++;
            model_fail();
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] exp_rstn();
    int n;
    if (m_phase == PH_RUN) return (32'd1 << NO) - 1;
    if (m_phase != PH_REL) return 0;
    n = m_t / ST + 1;
    if (n > NO) n = NO;
    return (32'd1 << n) - 1;
  endfunction

  task automatic step(input bit r, input bit e, input bit l);
    @(negedge clk);
    rst = r; en = e; lock = l;
    @(posedge clk);
    model_step(r, e, l);
    #1;
    chk("pd_n",  pd_n,  (m_phase >= PH_WAIT && m_phase <= PH_RUN) ? 1 : 0);
    chk("rst_n", rst_n, exp_rstn());
    chk("ready", ready, (m_phase == PH_RUN) ? 1 : 0);
    chk("fault", fault, m_fault);
    chk("retry", retry, m_retry);
`ifdef LOCK_LOSS_COUNTER_EN
    chk("llc",   llc,   m_llc);
`endif
  endtask

  task automatic run(input int n, input bit e, input bit l);
    for (int i = 0; i < n; i++) step(1'b0, e, l);
  endtask

  initial begin
    int lowcnt;
    int guard;
    int unsigned r0;
    rst = 1'b1; en = 1'b1; lock = 1'b0;
    m_phase = PH_DOWN; m_t = 0; m_retry = 0; m_fault = 0; m_llc = 0;
    h1 = 0; h2 = 0;

    // 1. Clean start: powerdown width, then lock 10 cycles after it rises.
    step(1, 1, 0);
    step(1, 1, 0);
    lowcnt = pd_n ? 0 : 1;
    for (int i = 0; i < 20 && !pd_n; i++) begin
      step(0, 1, 0);
      if (!pd_n) lowcnt++;
    end
    chk("pd_low_cycles", lowcnt, PD);
    run(9, 1, 0);
    run(2 + LSC + 2 * ST + 4, 1, 1);
    chk("start_ready", ready, 1);
    chk("start_rstn", rst_n, 3'b111);

    // 3. Lock loss in RUN, then relock.
    run(6, 1, 0);
    chk("loss_retry", retry, 1);
    chk("loss_rstn", rst_n, 0);
    run(60, 1, 1);
    chk("relock_ready", ready, 1);
    chk("relock_retry", retry, 0);
`ifdef LOCK_LOSS_COUNTER_EN
    chk("relock_llc", llc, 1);
`endif

    // 6. One-cycle reset pulse in RUN.
    step(1, 1, 1);
    chk("rst_pulse_pd", pd_n, 0);
    chk("rst_pulse_ready", ready, 0);
    chk("rst_pulse_rstn", rst_n, 0);

    // 2. Lock glitch during qualification.
    run(13, 1, 1);
    step(0, 1, 0);
    run(LSC, 1, 1);
    chk("glitch_no_release", rst_n, 0);
    run(60, 1, 1);
    chk("glitch_retry", retry, 0);
    chk("glitch_ready", ready, 1);

    // 4. Lock never returns: two failures reach FAULT.
    run(3, 1, 0);
    chk("to_retry1", retry, 1);
    run(PD + TO + 10, 1, 0);
    chk("to_fault", fault, 1);
    chk("to_retry2", retry, RL);
    run(40, 1, 1);
    chk("fault_pd_held", pd_n, 0);
    step(1, 1, 0);
    chk("fault_cleared", fault, 0);
    chk("fault_retry_cleared", retry, 0);

    // 5. Enable dropped mid-release, after bit 1.
    guard = 0;
    while (!(m_phase == PH_REL && exp_rstn() == 3) && guard < 200) begin
      step(0, 1, 1);
      guard++;
    end
    chk("rel_reached", guard < 200, 1);
    r0 = m_retry;
    step(0, 0, 1);
    chk("disable_rstn", rst_n, 0);
    chk("disable_retry", retry, r0);
    run(60, 1, 1);
    chk("reenable_ready", ready, 1);

    // Randomized enable/lock/reset traffic.
    for (int seg = 0; seg < 120; seg++) begin
      bit e, l;
      int len;
      e   = ($urandom_range(0, 15) != 0);
      l   = $urandom_range(0, 1);
      len = $urandom_range(1, 120);
      if ($urandom_range(0, 40) == 0) step(1, e, l);
      run(len, e, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
